packet_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one packet_handler input port among NUM_SRC
//  32-bit valid/ready/last streams. Grant is held for the whole packet (until an accepted last

---
 rtl/packet_stream_arbiter.sv | 117 +++++++++++
 tb/tb_packet_stream_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin arbiter for valid/ready/last streams.
// Grant is held per packet; overlength packets are cut and their tail drained.
module packet_stream_arbiter #(
  parameter  int NUM_SRC   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BEATS = 10,
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]        i_src_valid,
  input  logic [NUM_SRC-1:0]        i_src_last,
  output logic [NUM_SRC-1:0]        o_src_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  output logic                      o_last,
  input  logic                      i_ready,
  output logic [GW-1:0]             o_grant_id,
  output logic                      o_busy,
  output logic [NUM_SRC-1:0]        o_trunc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q;
  logic [GW-1:0]        gnt_q;
  logic [GW-1:0]        last_gnt_q;
  logic [CW-1:0]        beat_cnt_q;
  logic [NUM_SRC-1:0]   trunc_q;

  logic [GW-1:0]        pick;
  int                   idx;
  logic                 cur_vld;
  logic                 cur_lst;
  logic                 at_max;

  assign cur_vld = i_src_valid[gnt_q];
  assign cur_lst = i_src_last[gnt_q];
  assign at_max  = (beat_cnt_q == CW'(MAX_BEATS - 1));

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(last_gnt_q) + i) % NUM_SRC;
      if (i_src_valid[idx]) pick = GW'(idx);
    end
  end

  always_comb begin
    o_data      = '0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_src_ready = '0;
    unique case (state_q)
      XFER: begin
        o_data  = i_src_data[int'(gnt_q)*DATA_W +: DATA_W];
        o_valid = cur_vld;
        o_last  = cur_lst | at_max;
        o_src_ready[gnt_q] = i_ready;
      end
      DRAIN: o_src_ready[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  assign o_busy     = (state_q != IDLE);
  assign o_grant_id = o_busy ? gnt_q : '0;
  assign o_trunc    = trunc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NUM_SRC - 1);
      beat_cnt_q <= '0;
      trunc_q    <= '0;
    end else begin
      trunc_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|i_src_valid) begin
            gnt_q      <= pick;
            beat_cnt_q <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (cur_vld && i_ready) begin
            if (beat_cnt_q != CW'(MAX_BEATS))
              beat_cnt_q <= beat_cnt_q + CW'(1);
            if (cur_lst) begin
              state_q    <= IDLE;
              last_gnt_q <= gnt_q;
            end else if (at_max) begin
              state_q        <= DRAIN;
              last_gnt_q     <= gnt_q;
              trunc_q[gnt_q] <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cur_vld && cur_lst) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Directed bench for packet_stream_arbiter: vector table plus
// hand-written sequences for backpressure, reset and stall cases.
module tb_packet_stream_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] sdata;
  logic [N-1:0]   svld;
  logic [N-1:0]   slst;
  logic [N-1:0]   srdy;
  logic [W-1:0]   odata;
  logic           ovld;
  logic           olst;
  logic           rdy;
  logic [1:0]     gid;
  logic           obusy;
  logic [N-1:0]   trunc;

  int   checks = 0;
  int   fails  = 0;
  int   idx;
  int   got;
  logic r;

  always #5 clk = ~clk;

  packet_stream_arbiter #(
    .NUM_SRC(N), .DATA_W(W), .MAX_BEATS(10)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_src_data(sdata), .i_src_valid(svld), .i_src_last(slst),
    .o_src_ready(srdy), .o_data(odata), .o_valid(ovld),
    .o_last(olst), .i_ready(rdy), .o_grant_id(gid),
    .o_busy(obusy), .o_trunc(trunc)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        ev;
    logic        el;
    logic [3:0]  esr;
    logic [1:0]  eg;
    logic        eb;
    logic [3:0]  et;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sd(int k, logic [31:0] d);
    return {4'(k), d[27:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic drive(logic rs, logic [3:0] v, logic [3:0] l,
                       logic rd, logic [31:0] d);
    rst  = rs;
    svld = v;
    slst = l;
    rdy  = rd;
    for (int k = 0; k < N; k++) sdata[k*W +: W] = sd(k, d);
  endtask

  task automatic add(logic [3:0] v, logic [3:0] l, logic [31:0] d,
                     logic ev, logic el, logic [3:0] esr,
                     logic [1:0] eg, logic eb, logic [3:0] et);
    vec_t t;
    t.vld = v;  t.lst = l;  t.dat = d;
    t.ev  = ev; t.el  = el; t.esr = esr;
    t.eg  = eg; t.eb  = eb; t.et  = et;
    tbl.push_back(t);
  endtask

  initial begin
    // all sources, 3-beat packets: rotation 0,1,2,3,0
    for (int p = 0; p < 5; p++) begin
      add(4'hF, 4'h0, 32'h0, 0, 0, 4'h0, 2'd0, 0, 4'h0);
      for (int b = 0; b < 3; b++)
        add(4'hF, (b == 2) ? 4'hF : 4'h0, 32'(p*16 + b), 1, b == 2,
            4'(1 << (p % 4)), 2'(p % 4), 1, 4'h0);
    end
    // single source 2, six beats
    add(4'h4, 4'h0, 32'h1800_0F00, 0, 0, 4'h0, 2'd0, 0, 4'h0);
    for (int b = 0; b < 6; b++)
      add(4'h4, (b == 5) ? 4'h4 : 4'h0,
          (b == 0) ? 32'h1800_0F00 : (b == 1) ? 32'h0100_0000 : 32'(32'hA0 + b),
          1, b == 5, 4'h4, 2'd2, 1, 4'h0);
    // overlength src3: 10 out, 3 drained
    add(4'h8, 4'h0, 32'h0, 0, 0, 4'h0, 2'd0, 0, 4'h0);
    for (int b = 0; b < 10; b++)
      add(4'h8, 4'h0, 32'(32'hC0 + b), 1, b == 9, 4'h8, 2'd3, 1, 4'h0);
    for (int t = 0; t < 3; t++)
      add(4'h8, (t == 2) ? 4'h8 : 4'h0, 32'(32'hD0 + t), 0, 0,
          4'h8, 2'd3, 1, (t == 0) ? 4'h8 : 4'h0);
    add(4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 2'd0, 0, 4'h0);

    drive(1, 4'h0, 4'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    drive(0, 4'h0, 4'h0, 1, 32'h0);
    #1;
    chk("rst_valid", 32'(ovld), 0);
    chk("rst_last", 32'(olst), 0);
    chk("rst_srdy", 32'(srdy), 0);
    chk("rst_busy", 32'(obusy), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_trunc", 32'(trunc), 0);
    chk("rst_data", odata, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(0, tbl[i].vld, tbl[i].lst, 1, tbl[i].dat);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ovld), 32'(tbl[i].ev));
      chk($sformatf("v%0d_last", i), 32'(olst), 32'(tbl[i].el));
      chk($sformatf("v%0d_srdy", i), 32'(srdy), 32'(tbl[i].esr));
      chk($sformatf("v%0d_gid", i), 32'(gid), 32'(tbl[i].eg));
      chk($sformatf("v%0d_busy", i), 32'(obusy), 32'(tbl[i].eb));
      chk($sformatf("v%0d_trunc", i), 32'(trunc), 32'(tbl[i].et));
      if (tbl[i].ev)
        chk($sformatf("v%0d_data", i), odata,
            sd(int'(tbl[i].eg), tbl[i].dat));
    end

    // backpressure on src1, ready toggling 1010
    idx = 0;
    got = 0;
    @(negedge clk);
    drive(0, 4'b0010, 4'b0000, 1, 32'hB0);
    #1;
    chk("bp_idle", 32'(obusy), 0);
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) begin
        @(negedge clk);
        r = (c % 2 == 0);
        drive(0, 4'b0010, (idx == 3) ? 4'b0010 : 4'b0000, r,
              32'(32'hB0 + idx));
        #1;
        chk("bp_rdy", 32'(srdy), r ? 32'h2 : 32'h0);
        chk("bp_valid", 32'(ovld), 1);
        chk("bp_gid", 32'(gid), 1);
        if (ovld && rdy) begin
          chk("bp_beat", odata, sd(1, 32'(32'hB0 + got)));
          got++;
        end else begin
          chk("bp_hold", odata, sd(1, 32'(32'hB0 + idx)));
        end
        if (srdy[1] && svld[1]) idx++;
      end
    end
    chk("bp_src_cnt", 32'(idx), 4);
    chk("bp_sink_cnt", 32'(got), 4);
    @(negedge clk);
    drive(0, 4'h0, 4'h0, 1, 32'h0);
    #1;
    chk("bp_done", 32'(obusy), 0);

    // src0 one-beat packet so the pointer sits on 0
    @(negedge clk);
    drive(0, 4'b0001, 4'b0001, 1, 32'hE0);
    #1;
    chk("rs_pre_idle", 32'(obusy), 0);
    @(negedge clk);
    #1;
    chk("rs_pre_last", 32'(olst), 1);
    chk("rs_pre_srdy", 32'(srdy), 1);
    @(negedge clk);
    drive(0, 4'b0001, 4'b0000, 1, 32'hE1);
    #1;
    chk("rs_idle", 32'(obusy), 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive(0, 4'b0001, 4'b0000, 1, 32'(32'hE2 + b));
      #1;
      chk("rs_beat", 32'(ovld), 1);
    end
    @(negedge clk);
    drive(1, 4'b0001, 4'b0000, 1, 32'hE5);
    @(negedge clk);
    drive(0, 4'b0011, 4'b0000, 1, 32'hE6);
    #1;
    chk("rs_valid", 32'(ovld), 0);
    chk("rs_last", 32'(olst), 0);
    chk("rs_srdy", 32'(srdy), 0);
    chk("rs_busy", 32'(obusy), 0);
    chk("rs_gid", 32'(gid), 0);
    chk("rs_trunc", 32'(trunc), 0);
    chk("rs_data", odata, 0);
    @(negedge clk);
    drive(0, 4'b0011, 4'b0011, 1, 32'hE7);
    #1;
    chk("rs_regrant_gid", 32'(gid), 0);
    chk("rs_regrant_busy", 32'(obusy), 1);
    chk("rs_regrant_data", odata, sd(0, 32'hE7));

    // src1 stalls mid-packet while src2 requests
    @(negedge clk);
    drive(0, 4'b0010, 4'b0000, 1, 32'hF0);
    #1;
    chk("st_idle", 32'(obusy), 0);
    @(negedge clk);
    drive(0, 4'b0110, 4'b0000, 1, 32'hF1);
    #1;
    chk("st_gid", 32'(gid), 1);
    chk("st_valid", 32'(ovld), 1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      drive(0, 4'b0100, 4'b0000, 1, 32'hF2);
      #1;
      chk("st_stall_valid", 32'(ovld), 0);
      chk("st_stall_gid", 32'(gid), 1);
      chk("st_stall_busy", 32'(obusy), 1);
    end
    @(negedge clk);
    drive(0, 4'b0110, 4'b0010, 1, 32'hF3);
    #1;
    chk("st_end_valid", 32'(ovld), 1);
    chk("st_end_last", 32'(olst), 1);
    chk("st_end_gid", 32'(gid), 1);
    @(negedge clk);
    drive(0, 4'b0100, 4'b0000, 1, 32'hF4);
    #1;
    chk("st_gap", 32'(obusy), 0);
    @(negedge clk);
    drive(0, 4'b0100, 4'b0100, 1, 32'hF5);
    #1;
    chk("st_next_gid", 32'(gid), 2);
    chk("st_next_valid", 32'(ovld), 1);
    chk("st_next_data", odata, sd(2, 32'hF5));
    @(negedge clk);
    drive(0, 4'h0, 4'h0, 1, 32'h0);
    #1;
    chk("st_done", 32'(obusy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
